// File: rtl/pipe_stall_ctrl_if.sv
// Handshake bundle between the pipeline stages and the central stall/flush controller.
// The master modport is the pipeline side. The slave modport is the controller.
interface pipe_stall_ctrl_if;
    logic        inst_stall_req;
    logic        id_stall_req;
    logic        data_stall_req;
    logic        div_start;
    logic        exc_req;
    logic        exc_is_eret;
    logic [31:0] cp0_epc;
    logic        inst_bus_busy;
    logic        data_bus_busy;
    logic [3:0]  stall;
    logic        exception;
    logic [31:0] flush_pc;
    logic        div_busy;
    logic        wdt_timeout;

    modport master (
        output inst_stall_req, id_stall_req, data_stall_req, div_start,
               exc_req, exc_is_eret, cp0_epc, inst_bus_busy, data_bus_busy,
        input  stall, exception, flush_pc, div_busy, wdt_timeout
    );

    modport slave (
        input  inst_stall_req, id_stall_req, data_stall_req, div_start,
               exc_req, exc_is_eret, cp0_epc, inst_bus_busy, data_bus_busy,
        output stall, exception, flush_pc, div_busy, wdt_timeout
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush control for the 5-stage MIPS core: stall vector, drained exception redirect, divider timing.
// Optional stall watchdog is built only when STALL_WDT_EN is defined.
module pipe_stall_ctrl #(
    parameter int unsigned DIV_CYCLES = 33,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
    parameter int unsigned WDT_LIMIT  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    pipe_stall_ctrl_if.slave  ctl
);

    localparam logic [1:0] ST_RUN   = 2'b00;
    localparam logic [1:0] ST_DRAIN = 2'b01;
    localparam logic [1:0] ST_FLUSH = 2'b10;

    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

    if (DIV_CYCLES < 2 || DIV_CYCLES > 63 || WDT_LIMIT == 0) begin : g_param_check
        $error("pipe_stall_ctrl: DIV_CYCLES must be 2..63 and WDT_LIMIT nonzero");
    end

    logic [1:0]  state_r;
    logic [1:0]  next_state_s;
    logic [31:0] target_r;
    logic [31:0] target_now_s;
    logic        exception_r;
    logic [31:0] flush_pc_r;
    logic [5:0]  div_cnt_r;
    logic        div_idle_run_s;
    logic        div_accept_s;
    logic        div_busy_s;
    logic [3:0]  stall_s;
    logic        bus_busy_s;

    assign bus_busy_s     = ctl.inst_bus_busy | ctl.data_bus_busy;
    assign target_now_s   = ctl.exc_is_eret ? ctl.cp0_epc : EXC_VECTOR;
    assign div_idle_run_s = (state_r == ST_RUN) && (div_cnt_r == 6'd0);
    assign div_busy_s     = (ctl.div_start & div_idle_run_s) | (div_cnt_r != 6'd0);
    // A same-cycle exception wins over a divide start, so the counter is not loaded.
    assign div_accept_s   = ctl.div_start & div_idle_run_s & ~ctl.exc_req;

    // Next-state decision for the redirect sequencer.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (ctl.exc_req) begin
                    next_state_s = bus_busy_s ? ST_DRAIN : ST_FLUSH;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!bus_busy_s) begin
                    next_state_s = ST_FLUSH;
                end else begin
                    next_state_s = ST_DRAIN;
                end
            end
            ST_FLUSH: next_state_s = ST_RUN;
            default:  next_state_s = ST_RUN;
        endcase
    end

    // Stall vector: raw requests while running, full freeze while draining, released during the flush.
    always_comb begin
        stall_s = 4'b0000;
        case (state_r)
            ST_RUN:   stall_s = {ctl.data_stall_req, div_busy_s, ctl.id_stall_req, ctl.inst_stall_req};
            ST_DRAIN: stall_s = 4'b1111;
            ST_FLUSH: stall_s = 4'b0000;
            default:  stall_s = 4'b0000;
        endcase
    end

    // Sequencer state, redirect target latch and the one-cycle flush pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_RUN;
            target_r    <= 32'h0000_0000;
            exception_r <= 1'b0;
            flush_pc_r  <= 32'h0000_0000;
        end else begin
            state_r <= next_state_s;
            if (state_r == ST_RUN && ctl.exc_req) begin
                target_r <= target_now_s;
            end
            exception_r <= (next_state_s == ST_FLUSH);
            if (next_state_s == ST_FLUSH) begin
                flush_pc_r <= (state_r == ST_RUN) ? target_now_s : target_r;
            end else begin
                flush_pc_r <= 32'h0000_0000;
            end
        end
    end

    // Divider stall window; the flush aborts any divide in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_r <= 6'd0;
        end else if (state_r == ST_FLUSH) begin
            div_cnt_r <= 6'd0;
        end else if (div_accept_s) begin
            div_cnt_r <= DIV_LOAD;
        end else if (div_cnt_r != 6'd0) begin
            div_cnt_r <= div_cnt_r - 6'd1;
        end
    end

`ifdef STALL_WDT_EN
    logic [31:0] wdt_cnt_r;
    logic        wdt_timeout_r;
    logic        stalled_s;

    assign stalled_s = (stall_s != 4'b0000);

    // Saturating count of consecutive stalled cycles; the timeout flag is sticky until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdt_cnt_r     <= 32'd0;
            wdt_timeout_r <= 1'b0;
        end else begin
            if (!stalled_s) begin
                wdt_cnt_r <= 32'd0;
            end else if (wdt_cnt_r < 32'(WDT_LIMIT)) begin
                wdt_cnt_r <= wdt_cnt_r + 32'd1;
            end
            if (stalled_s && (wdt_cnt_r + 32'd1 >= 32'(WDT_LIMIT))) begin
                wdt_timeout_r <= 1'b1;
            end
        end
    end

    assign ctl.wdt_timeout = wdt_timeout_r;
`else
    assign ctl.wdt_timeout = 1'b0;
`endif

    assign ctl.stall     = stall_s;
    assign ctl.exception = exception_r;
    assign ctl.flush_pc  = flush_pc_r;
    assign ctl.div_busy  = div_busy_s;

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central pipeline control for the 5-stage MIPS core.
- Produces the 4-bit stall vector and the exception flush pulse consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Sequences exception/ERET redirects so a flush never lands while an AXI instruction or data transaction is outstanding.
- Times the multi-cycle divider stall internally.

Parameters:
- DIV_CYCLES, 33: total EX-stall cycles per divide, including the start cycle; legal range 2..63.
- EXC_VECTOR, 32'hBFC00380: general exception entry PC.
- WDT_LIMIT, 1024: consecutive-stall cycle limit; only used under STALL_WDT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- inst_stall_req  in  1  IF waiting on instruction bus
- id_stall_req  in  1  ID load-use hazard
- data_stall_req  in  1  MEM waiting on data bus
- div_start  in  1  EX issuing div/divu this cycle
- exc_req  in  1  MEM commits exception or ERET this cycle
- exc_is_eret  in  1  qualifies exc_req as ERET
- cp0_epc  in  32  EPC value, used when exc_is_eret=1
- inst_bus_busy  in  1  instruction AXI read outstanding
- data_bus_busy  in  1  data AXI read or write outstanding
- stall  out  4  [0]=inst, [1]=id, [2]=exe, [3]=data
- exception  out  1  registered one-cycle flush pulse to all pipeline registers
- flush_pc  out  32  redirect PC; valid while exception=1
- div_busy  out  1  divider stall window active
- wdt_timeout  out  1  sticky stall watchdog flag

Behaviour:
- Reset values:
  - state=RUN, div_cnt=0, stall=0, exception=0, flush_pc=0, wdt_timeout=0.
  - Reset is asynchronous and may occur mid-DRAIN or mid-divide; both are abandoned.
- States: RUN, DRAIN, FLUSH.
- RUN:
  - exc_req=1 latches the target: cp0_epc if exc_is_eret, else EXC_VECTOR.
  - Next state is DRAIN if inst_bus_busy|data_bus_busy, else FLUSH.
- DRAIN:
  - stall=4'b1111.
  - exc_req ignored.
  - Go to FLUSH in the first cycle both busy inputs are 0.
- FLUSH:
  - exception=1 and flush_pc=latched target for exactly one cycle.
  - stall=0; div_cnt cleared, which aborts any divide.
  - Return to RUN next cycle; exc_req in this cycle is ignored.
- Stall vector in RUN (combinational from inputs plus registered state):
  - stall[3]=data_stall_req
  - stall[2]=div_busy
  - stall[1]=id_stall_req
  - stall[0]=inst_stall_req
  - Bits are not priority-masked; the pipeline registers give exe/data precedence.
- Divider:
  - div_busy = (div_start & state==RUN & div_cnt==0) | (div_cnt!=0).
  - On an accepted div_start, load div_cnt=DIV_CYCLES-1; decrement each cycle while nonzero.
  - Result: div_busy is high for exactly DIV_CYCLES cycles starting with the start cycle.
  - div_start while div_cnt!=0 is ignored (no reload).
  - div_cnt keeps counting through data/inst stalls.
- Simultaneous events:
  - exc_req and div_start in the same RUN cycle: exception wins, div_cnt is not loaded.
  - Exception taken while a divide is in progress: the divide is aborted on FLUSH entry.
- exception is a flop output, so it asserts the cycle after the FLUSH transition decision.

Optional Feature:
- Macro: STALL_WDT_EN.
- Defined:
  - A 32-bit counter increments each cycle stall!=0 and clears when stall==0.
  - When the count reaches WDT_LIMIT, wdt_timeout goes to 1 and stays there until rst.
  - The counter saturates at WDT_LIMIT.
- Not defined: no counter is built; wdt_timeout is tied to 0.

Test Plan:
- Reset release, all inputs 0 -> stall=0, exception=0, flush_pc=0, div_busy=0 for 10 cycles.
- div_start pulse at cycle 5 with DIV_CYCLES=33 -> stall[2]=1 on cycles 5..37, 0 at 38. A second div_start at cycle 10 does not extend the window.
- exc_req=1, exc_is_eret=0, buses idle -> one cycle later exception=1 for one cycle, flush_pc=32'hBFC00380, stall=0.
- exc_req=1, exc_is_eret=1, cp0_epc=32'h80001234, data_bus_busy high 4 more cycles:
  - stall=4'b1111 for those 4 cycles;
  - then exception=1 with flush_pc=32'h80001234.
- div_start and exc_req in the same cycle -> div_busy drops after that cycle, exception pulse follows; rst asserted mid-DRAIN -> immediate return to reset values, no exception pulse.
- With STALL_WDT_EN and WDT_LIMIT=16:
  - inst_stall_req held 16 cycles -> wdt_timeout=1 and it remains 1 after the request drops;
  - a 15-cycle stall followed by 1 idle cycle -> wdt_timeout stays 0.
